// File: rtl/cpu_pkg.sv
// Shared core definitions: branch encodings, fetch address constants, pc_gen FSM states.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BR_W = 3;

    localparam logic [BR_W-1:0] BR_NONE = 3'd0;
    localparam logic [BR_W-1:0] BR_BEQ  = 3'd1;
    localparam logic [BR_W-1:0] BR_BNE  = 3'd2;
    localparam logic [BR_W-1:0] BR_BLEZ = 3'd3;
    localparam logic [BR_W-1:0] BR_BGTZ = 3'd4;
    localparam logic [BR_W-1:0] BR_BGEZ = 3'd5;
    localparam logic [BR_W-1:0] BR_BLTZ = 3'd6;

    localparam logic [XLEN-1:0] PC_RESET   = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_EXC_VEC = 32'h0000_4180;
    localparam logic [XLEN-1:0] PC_IMEM_LO = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_IMEM_HI = 32'h0000_6ffc;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pc_state_e;

    // Encodings 0 and 7 are both "no branch".
    function automatic logic is_branch(input logic [BR_W-1:0] op);
        return (op >= BR_BEQ) && (op <= BR_BLTZ);
    endfunction

endpackage

// File: rtl/npc_target.sv
// D-stage redirect target and change_d; purely combinational, gated off while flushing.
module npc_target
    import cpu_pkg::*;
(
    input  logic [BR_W-1:0] branchop,
    input  logic            cmp_res,
    input  logic            jump,
    input  logic            jr_sel,
    input  logic [25:0]     instr_idx,
    input  logic [XLEN-1:0] pc4_d,
    input  logic [XLEN-1:0] jr_addr,
    input  logic            flush,
    output logic [XLEN-1:0] target,
    output logic            br_c,
    output logic            change_d
);

    logic            w_taken;
    logic [XLEN-1:0] w_br_off;

    assign br_c     = is_branch(branchop);
    assign w_taken  = br_c & cmp_res;
    assign w_br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
    assign change_d = ~flush & (w_taken | jump | jr_sel);

    // Branch beats jump beats jr; the mux is always fully specified.
    always_comb begin
        target = jr_addr;
        if (w_taken) begin
            target = pc4_d + w_br_off;
        end else if (jump) begin
            target = {pc4_d[31:28], instr_idx, 2'b00};
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register, RUN/FLUSH sequencing and delay-slot flag.
// Optional fetch address error checking is built when PC_GEN_ADEL_EN is defined.
module pc_gen
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = PC_RESET,
`ifdef PC_GEN_ADEL_EN
    parameter logic [XLEN-1:0] IMEM_LO  = PC_IMEM_LO,
    parameter logic [XLEN-1:0] IMEM_HI  = PC_IMEM_HI,
`endif
    parameter logic [XLEN-1:0] EXC_VEC  = PC_EXC_VEC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [BR_W-1:0] branchop,
    input  logic            cmp_res,
    input  logic            jump,
    input  logic            jr_sel,
    input  logic [XLEN-1:0] ins_d,
    input  logic [XLEN-1:0] pc4_d,
    input  logic [XLEN-1:0] jr_addr,
    input  logic            exc_req,
    input  logic            eret,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc4_f,
    output logic            change_d,
    output logic            bd_f,
    output logic            adel_f
);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_bd;
    logic            w_bd_nxt;
    logic [XLEN-1:0] w_target;
    logic            w_br;
    logic            w_flush;
    logic            w_unused_bits;

    assign w_flush       = (r_state == FLUSH);
    assign w_unused_bits = ^{ins_d[31:26], epc[1:0]};

    npc_target u_npc_target (
        .branchop  (branchop),
        .cmp_res   (cmp_res),
        .jump      (jump),
        .jr_sel    (jr_sel),
        .instr_idx (ins_d[25:0]),
        .pc4_d     (pc4_d),
        .jr_addr   (jr_addr),
        .flush     (w_flush),
        .target    (w_target),
        .br_c      (w_br),
        .change_d  (change_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_bd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_bd    <= w_bd_nxt;
        end
    end

    // Exception entry and eret override stall; a new exception re-arms FLUSH.
    always_comb begin
        w_state_nxt = RUN;
        w_pc_nxt    = pc4_f;
        w_bd_nxt    = 1'b0;
        if (exc_req) begin
            w_state_nxt = FLUSH;
            w_pc_nxt    = EXC_VEC;
        end else if (eret) begin
            w_state_nxt = FLUSH;
            w_pc_nxt    = {epc[31:2], 2'b00};
        end else if (stall) begin
            w_pc_nxt = r_pc;
            w_bd_nxt = w_flush ? 1'b0 : r_bd;
        end else begin
            if (change_d) begin
                w_pc_nxt = w_target;
            end
            w_bd_nxt = change_d | (~w_flush & w_br & ~cmp_res);
        end
    end

    assign pc_f  = r_pc;
    assign pc4_f = r_pc + 32'd4;
    assign bd_f  = r_bd;

`ifdef PC_GEN_ADEL_EN
    assign adel_f = (r_pc[1:0] != 2'b00) | (r_pc < IMEM_LO) | (r_pc > IMEM_HI);
`else
    assign adel_f = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with hand-computed expected fetch addresses.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  branchop;
    logic        cmp_res;
    logic        jump;
    logic        jr_sel;
    logic [31:0] ins_d;
    logic [31:0] pc4_d;
    logic [31:0] jr_addr;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
    logic        change_d;
    logic        bd_f;
    logic        adel_f;

    int n_tests;
    int n_fail;

`ifdef PC_GEN_ADEL_EN
    localparam logic ADEL_ON = 1'b1;
`else
    localparam logic ADEL_ON = 1'b0;
`endif

    pc_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .branchop (branchop),
        .cmp_res  (cmp_res),
        .jump     (jump),
        .jr_sel   (jr_sel),
        .ins_d    (ins_d),
        .pc4_d    (pc4_d),
        .jr_addr  (jr_addr),
        .exc_req  (exc_req),
        .eret     (eret),
        .epc      (epc),
        .pc_f     (pc_f),
        .pc4_f    (pc4_f),
        .change_d (change_d),
        .bd_f     (bd_f),
        .adel_f   (adel_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall    = 1'b0;
        branchop = 3'd0;
        cmp_res  = 1'b0;
        jump     = 1'b0;
        jr_sel   = 1'b0;
        ins_d    = 32'h0;
        pc4_d    = 32'h0;
        jr_addr  = 32'h0;
        exc_req  = 1'b0;
        eret     = 1'b0;
        epc      = 32'h0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_pc", pc_f, 32'h3000);
        check("rst_pc4", pc4_f, 32'h3004);
        check("rst_bd", 32'(bd_f), 32'h0);
        check("rst_adel", 32'(adel_f), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        tick(); check("seq_1", pc_f, 32'h3004);
        tick(); check("seq_2", pc_f, 32'h3008);
        check("seq_bd", 32'(bd_f), 32'h0);

        // Backward taken beq: 0x3008 - 8
        pc4_d = 32'h3008; branchop = 3'd1; cmp_res = 1'b1; ins_d = 32'h1000_FFFE;
        #1 check("br_change", 32'(change_d), 32'h1);
        tick(); check("br_pc", pc_f, 32'h3000);
        check("br_bd", 32'(bd_f), 32'h1);
        idle_inputs();
        tick(); check("br_slot_pc", pc_f, 32'h3004);
        check("br_slot_bd", 32'(bd_f), 32'h0);

        // Not-taken branch still marks its delay slot
        branchop = 3'd2; cmp_res = 1'b0; pc4_d = 32'h3004; ins_d = 32'h1400_0010;
        #1 check("nt_change", 32'(change_d), 32'h0);
        tick(); check("nt_pc", pc_f, 32'h3008);
        check("nt_bd", 32'(bd_f), 32'h1);
        idle_inputs();

        // Jump held by stall for three cycles
        stall = 1'b1; jump = 1'b1; pc4_d = 32'h3010; ins_d = 32'h0800_0C40;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_pc", pc_f, 32'h3008);
            check("stall_bd", 32'(bd_f), 32'h1);
        end
        stall = 1'b0;
        tick(); check("jmp_pc", pc_f, 32'h3100);
        check("jmp_bd", 32'(bd_f), 32'h1);
        idle_inputs();

        // Exception beats stall and a taken branch
        stall = 1'b1; branchop = 3'd1; cmp_res = 1'b1; pc4_d = 32'h3104; ins_d = 32'h1000_0010;
        exc_req = 1'b1;
        tick(); check("exc_pc", pc_f, 32'h4180);
        check("exc_bd", 32'(bd_f), 32'h0);
        idle_inputs();
        jump = 1'b1; pc4_d = 32'h4184; ins_d = 32'h0800_0C40;
        #1 check("flush_change", 32'(change_d), 32'h0);
        tick(); check("flush_pc", pc_f, 32'h4184);
        check("flush_bd", 32'(bd_f), 32'h0);
        #1 check("run_change", 32'(change_d), 32'h1);
        idle_inputs();

        // eret to EPC, low bits ignored
        eret = 1'b1; epc = 32'h0000_3027;
        tick(); check("eret_pc", pc_f, 32'h3024);
        check("eret_bd", 32'(bd_f), 32'h0);
        idle_inputs();
        tick(); check("eret_next", pc_f, 32'h3028);

        // Simultaneous exc_req and eret, then re-entry while in FLUSH
        exc_req = 1'b1; eret = 1'b1; epc = 32'h3024;
        tick(); check("exc_eret_pc", pc_f, 32'h4180);
        eret = 1'b0;
        tick(); check("exc_in_flush", pc_f, 32'h4180);
        exc_req = 1'b0; jump = 1'b1; ins_d = 32'h0800_0C40; pc4_d = 32'h4184;
        #1 check("reflush_change", 32'(change_d), 32'h0);
        tick(); check("reflush_pc", pc_f, 32'h4184);
        idle_inputs();

        // jr targets and address error flag
        jr_sel = 1'b1; jr_addr = 32'h3002;
        #1 check("jr_change", 32'(change_d), 32'h1);
        tick(); check("jr_pc", pc_f, 32'h3002);
        check("adel_misalign", 32'(adel_f), 32'(ADEL_ON));
        jr_addr = 32'h7000;
        tick(); check("jr_hi_pc", pc_f, 32'h7000);
        check("adel_high", 32'(adel_f), 32'(ADEL_ON));
        jr_addr = 32'h6ffc;
        tick(); check("adel_edge", 32'(adel_f), 32'h0);
        idle_inputs();

        // Branch has priority over jump and jr
        branchop = 3'd1; cmp_res = 1'b1; jump = 1'b1; jr_sel = 1'b1;
        jr_addr = 32'h5000; pc4_d = 32'h3000; ins_d = 32'h1000_0004;
        tick(); check("prio_pc", pc_f, 32'h3010);
        // Jump has priority over jr
        branchop = 3'd7; pc4_d = 32'h3014; ins_d = 32'h0800_0C40;
        tick(); check("prio_jmp", pc_f, 32'h3100);
        check("br7_bd", 32'(bd_f), 32'h1);
        // Target wraps modulo 2^32
        branchop = 3'd1; jump = 1'b0; jr_sel = 1'b0; pc4_d = 32'hFFFF_FFFC; ins_d = 32'h1000_0001;
        tick(); check("wrap_pc", pc_f, 32'h0);
        check("adel_low", 32'(adel_f), 32'(ADEL_ON));
        idle_inputs();

        // Asynchronous reset mid-cycle
        tick();
        #2 rst_n = 1'b0;
        #1 check("async_rst_pc", pc_f, 32'h3000);
        check("async_rst_bd", 32'(bd_f), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); check("post_rst_pc", pc_f, 32'h3004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the pipelined MIPS core with precise exceptions. It owns the architectural fetch PC register and resolves the next fetch address. Sources are D-stage branch/jump/jr decisions, exception entry and `eret` return. It also flags delay-slot fetches for EPC/BD bookkeeping and, optionally, misaligned or out-of-range fetch addresses. It sits between the F-stage instruction memory and the D-stage comparator/decoder, replacing the purely combinational next-PC mux.

## Interface
- `RESET_PC`, 32'h0000_3000, fetch address after reset
- `EXC_VEC`, 32'h0000_4180, exception/interrupt handler entry
- `IMEM_LO`, 32'h0000_3000, lowest legal fetch address
- `IMEM_HI`, 32'h0000_6ffc, highest legal fetch address
- `clk`  in  1  single core clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold F/D (hazard unit)
- `branchop`  in  3  D-stage branch type; 1..6 = branch, 0/7 = none
- `cmp_res`  in  1  D-stage branch condition result
- `jump`  in  1  D-stage j/jal
- `jr_sel`  in  1  D-stage jr/jalr
- `ins_d`  in  32  D-stage instruction word
- `pc4_d`  in  32  D-stage PC+4
- `jr_addr`  in  32  forwarded rs value
- `exc_req`  in  1  exception/interrupt accepted by CP0 this cycle
- `eret`  in  1  eret committing this cycle
- `epc`  in  32  CP0 EPC
- `pc_f`  out  32  current fetch address (registered)
- `pc4_f`  out  32  pc_f + 4
- `change_d`  out  1  D-stage control transfer taken (combinational)
- `bd_f`  out  1  instruction at pc_f is a delay slot (registered)
- `adel_f`  out  1  fetch address error (see Configuration)

## Operation
- Branch target: `pc4_d + {{14{imm16[15]}}, imm16, 2'b00}`. Jump target: `{pc4_d[31:28], ins_d[25:0], 2'b00}`. Jr target: `jr_addr`.
- `change_d = ((branchop in 1..6) & cmp_res) | jump | jr_sel`, forced 0 in state FLUSH.
- D-stage target priority: branch > jump > jr. The next-address mux is fully defined every cycle; no latches.
- pc_f update priority, highest first:
  - `exc_req` -> EXC_VEC
  - `eret` -> `{epc[31:2], 2'b00}`
  - `stall` -> hold
  - `change_d` -> target
  - otherwise -> pc4_f
- `exc_req` and `eret` override `stall`. `exc_req` wins over a simultaneous `eret`.
- FSM with two states:
  - RUN: normal operation. `exc_req` or `eret` -> FLUSH.
  - FLUSH: exactly one cycle, then RUN. D holds a flushed bubble, so D-stage redirect inputs are ignored. `exc_req` in FLUSH is still honoured: pc_f <= EXC_VEC and the FSM stays in FLUSH one more cycle.
- bd_f:
  - On a non-stalled advance, bd_f <= change_d | (RUN & ((branchop in 1..6) & ~cmp_res)). Branches flag their delay slot whether taken or not.
  - Held on stall.
  - Cleared on `exc_req`/`eret` and in FLUSH.
- All address arithmetic is 32-bit modulo 2^32; wrap is not trapped.

## Timing
- Reset, asynchronous: pc_f = RESET_PC, pc4_f = RESET_PC+4, bd_f = 0, state = RUN, adel_f reflects RESET_PC (0 with defaults).
- Reset asserted mid-operation clears state immediately, independent of clk.
- Redirect latency is one cycle: a decision sampled at edge N is visible on pc_f after edge N.
- change_d is combinational from D inputs, for the F/D flush/delay logic, with zero latency.
- adel_f is combinational from pc_f.

## Configuration
- `PC_GEN_ADEL_EN` defined:
  - adel_f = (pc_f[1:0] != 0) | (pc_f < IMEM_LO) | (pc_f > IMEM_HI).
  - A misaligned jr target or eret to a bad EPC is reported in the cycle after the redirect.
- Not defined: adel_f tied 0, and comparators are not synthesised.

## Structure
- Shared package `cpu_pkg` holds:
  - branchop encodings (`BR_NONE`, `BR_BEQ`..`BR_BLTZ`)
  - reset/vector address constants
  - the FSM state typedef {RUN, FLUSH}
- One natural sub-module, `npc_target`, computes the D-stage target and change_d. It is purely combinational with the FLUSH gate input. pc_gen holds the register, FSM, bd_f and adel logic.

## Test plan
- Reset release, no inputs -> pc_f 0x3000, 0x3004, 0x3008 on successive edges; bd_f 0.
- At pc4_d=0x3008, branchop=1, cmp_res=1, imm16=0xFFFE -> change_d=1 same cycle; next pc_f=0x3000; following fetch bd_f=1.
- `stall` high 3 cycles while jump with ins_d[25:0]=0x0000C40 -> pc_f held; after release pc_f=0x3100.
- `exc_req` together with `stall` and a taken branch -> next pc_f=0x4180; FLUSH for one cycle with change_d=0 despite jump=1; then RUN.
- `eret` with epc=0x3024 -> pc_f=0x3024, bd_f=0; simultaneous `exc_req`+`eret` -> pc_f=0x4180.
- With `PC_GEN_ADEL_EN`, jr_sel and jr_addr=0x3002 -> pc_f=0x3002 and adel_f=1; jr_addr=0x7000 -> adel_f=1. Without the macro, adel_f stays 0.
